// File: rtl/rr_index_arbiter_pkg.sv
// Shared constants for the round-robin index arbiter: requester count, index width,
// FSM state codes and watchdog counter width.
package rr_arb_pkg;

  localparam int ARB_IDX_W = 4;
  localparam int ARB_N_REQ = 2 ** ARB_IDX_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int WDOG_W = 8;

endpackage

// File: rtl/rr_index_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the downstream decoder.
// The master side drives requests and acknowledges; the slave side (arbiter) drives grants.
interface rr_index_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ,
  parameter int IDX_W = ARB_IDX_W
);

  logic [N_REQ-1:0] REQ;
  logic             ACK;
  logic [IDX_W-1:0] GNT_IDX;
  logic             GNT_VALID;
  logic             TIMEOUT_FLAG;

  modport master (
    output REQ,
    output ACK,
    input  GNT_IDX,
    input  GNT_VALID,
    input  TIMEOUT_FLAG
  );

  modport slave (
    input  REQ,
    input  ACK,
    output GNT_IDX,
    output GNT_VALID,
    output TIMEOUT_FLAG
  );

endinterface

// File: rtl/rr_index_arbiter_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at the top.
// Rotate so ptr sits at bit 0, priority-encode the lowest set bit, then add ptr back.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  assign rot = N_REQ'({req, req} >> ptr);

  // Downward scan so the lowest set bit is the one left in off.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
  end

  assign pick    = ptr + off;
  assign any_req = |req;

endmodule

// File: rtl/rr_index_arbiter.sv
// 16-way round-robin arbiter producing an encoded grant index for a 4-to-16 decoder.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
module rr_index_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ       = ARB_N_REQ,
  parameter int IDX_W       = ARB_IDX_W,
  parameter int TIMEOUT_CYC = 64
) (
  input logic               CLK,
  input logic               RST,
  rr_index_arbiter_if.slave bus
);

  logic [0:0]       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             ack_live;
  logic             any_req;

  // An ACK on a live grant moves priority past the grantee before this cycle's pick.
  assign next_ptr = gnt_idx_q + IDX_W'(1);
  assign ack_live = (state_q == ST_GRANT) && bus.ACK;
  assign pick_ptr = ack_live ? next_ptr : ptr_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.REQ),
    .ptr     (pick_ptr),
    .pick    (pick_idx),
    .any_req (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              tflag_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      wdog_q    <= '0;
      tflag_q   <= 1'b0;
    end else begin
      tflag_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (any_req) begin
          gnt_idx_q <= pick_idx;
          state_q   <= ST_GRANT;
          wdog_q    <= '0;
        end
      end else if (bus.ACK) begin
        ptr_q <= next_ptr;
        if (any_req) begin
          gnt_idx_q <= pick_idx;
          wdog_q    <= '0;
        end else begin
          state_q <= ST_IDLE;
        end
      // wdog_q counts completed grant cycles minus one, so the limit hits on edge TIMEOUT_CYC.
      end else if (wdog_q == WDOG_LAST) begin
        ptr_q   <= next_ptr;
        state_q <= ST_IDLE;
        tflag_q <= 1'b1;
      end else begin
        wdog_q <= wdog_q + WDOG_W'(1);
      end
    end
  end

  assign bus.TIMEOUT_FLAG = tflag_q;
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (any_req) begin
          gnt_idx_q <= pick_idx;
          state_q   <= ST_GRANT;
        end
      end else if (bus.ACK) begin
        ptr_q <= next_ptr;
        if (any_req) begin
          gnt_idx_q <= pick_idx;
        end else begin
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign bus.TIMEOUT_FLAG = 1'b0;
`endif

  assign bus.GNT_IDX   = gnt_idx_q;
  assign bus.GNT_VALID = (state_q == ST_GRANT);

endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
16-input round-robin arbiter that drives the 4-bit select code into the downstream 4-to-16 decoder. It picks one requester per grant and holds that grant until the consumer acknowledges it. It then rotates priority so that every requester is eventually served. The output is an encoded index plus a valid flag; one-hot expansion is done downstream by the decoder.

Parameters:
N_REQ, 16, number of requesters; fixed at 2**IDX_W.
IDX_W, 4, width of the grant index.
TIMEOUT_CYC, 64, grant watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
CLK  input  1  single clock, rising edge.
RST  input  1  synchronous, active-high reset.
REQ  input  N_REQ  request vector; bit i set = requester i wants service.
ACK  input  1  consumer done with the current grant; sampled only while GNT_VALID=1.
GNT_IDX  output  IDX_W  index of the granted requester; feeds the decoder input.
GNT_VALID  output  1  GNT_IDX holds a live grant.
TIMEOUT_FLAG  output  1  one-cycle pulse when the watchdog revokes a grant; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is synchronous and active-high. All state changes on the rising edge of CLK.
- Reset values: GNT_IDX=0, GNT_VALID=0, TIMEOUT_FLAG=0, priority pointer PTR=0, state IDLE, watchdog count=0.
- RST asserted mid-grant: the grant is dropped at the next edge, with no ACK required and PTR back to 0.
- States: IDLE (no grant) and GRANT (grant held).
- Pick function: the first set bit of REQ, scanning upward from PTR and wrapping 15 -> 0.
  - Example: PTR=14, REQ=0x0003 -> pick 0.
- IDLE:
  - REQ != 0 -> next edge: GNT_IDX=pick, GNT_VALID=1, go to GRANT.
  - REQ == 0 -> stay in IDLE.
  - Latency: one cycle from REQ to GNT_VALID.
- GRANT:
  - GNT_IDX is stable for the whole grant.
  - No preemption: the grant is held even if REQ[GNT_IDX] drops.
  - ACK=1 -> PTR=(GNT_IDX+1) mod 16.
  - On ACK, the pick is computed with the new PTR in the same cycle.
  - ACK=1 and REQ != 0 -> back-to-back grant to the pick, with no idle cycle.
  - ACK=1 and REQ == 0 -> GNT_VALID=0, go to IDLE.
- Fairness: the current grantee has lowest priority for the next pick. A lone persistent requester is re-granted on every ACK.
- ACK while GNT_VALID=0 is ignored, with no pointer change.
- Index arithmetic is modulo 16 with natural IDX_W-bit wrap; no saturation.
- REQ is sampled synchronously; no synchronizers inside the block.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles in GRANT without ACK and clears on every new grant.
  - On reaching TIMEOUT_CYC it revokes the grant at that edge: GNT_VALID=0, TIMEOUT_FLAG=1 for one cycle, PTR=(GNT_IDX+1) mod 16, go to IDLE.
  - Revoke timing: with TIMEOUT_CYC=N, N cycles of GNT_VALID=1 and ACK=0 end the grant on edge N.
  - ACK arriving in the same cycle the count reaches the limit wins: normal completion, no flag.
- Not defined:
  - No counter logic; grants are held indefinitely.
  - TIMEOUT_FLAG is constant 0.
  - TIMEOUT_CYC is unused.

Decomposition:
- Package rr_arb_pkg:
  - IDX_W and N_REQ constants.
  - State encoding (IDLE=1'b0, GRANT=1'b1).
  - Watchdog width constant (8).
- One natural sub-module, rr_pick:
  - Purely combinational: REQ + PTR -> pick index + any_req.
  - Implemented as rotate, priority encode, un-rotate.
  - Instantiated once.
- Top holds the state register, PTR, output registers and the watchdog.

Test Plan:
- Reset: drive REQ=0xFFFF with RST=1 for 3 cycles -> GNT_VALID=0, GNT_IDX=0 throughout. Release RST -> one cycle later GNT_IDX=0, GNT_VALID=1.
- Rotation: REQ=0xFFFF held, ACK=1 every grant cycle -> GNT_IDX sequence 0,1,2,...,15,0 with GNT_VALID continuously 1.
- Wrap and skip: PTR=14 (after a grant to 13), REQ=0x8005 -> grants in order 15, 0, 2.
- Hold and no preemption: grant idx 5, drop REQ[5], ACK=0 for 10 cycles -> GNT_IDX=5 and GNT_VALID=1 for all 10. ACK with REQ=0 -> GNT_VALID=0 next cycle.
- Spurious ACK: GNT_VALID=0, pulse ACK, then REQ=0x0010 -> PTR unchanged, grant idx 4 one cycle after REQ.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT_CYC=4): grant idx 3, ACK held 0 -> GNT_VALID falls after 4 grant cycles, TIMEOUT_FLAG pulses once. With REQ=0x0018 still set, the next grant is idx 4. Without the macro the grant holds and TIMEOUT_FLAG stays 0.
